// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor: one WIDTH/STAGES-bit segment summed per stage, carry registered between stages.
// Define PIPE_ADDER_SAT_EN to add the 'sat' input that clamps overflowing results to the signed limits.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
`ifdef PIPE_ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG     = WIDTH / STAGES;
    localparam int LAST    = STAGES - 1;
    localparam bit USE_CLA = (SEG % 16) == 0;

    // 16-bit carry-lookahead: 4-bit groups with lookahead across groups.
    function automatic logic [16:0] cla16(input logic [15:0] x, input logic [15:0] y, input logic ci);
        logic [15:0] g;
        logic [15:0] p;
        logic [15:0] c;
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        g = x & y;
        p = x ^ y;
        for (int n = 0; n < 4; n++) begin
            gg[n] = g[4*n+3] | (p[4*n+3] & g[4*n+2]) | (p[4*n+3] & p[4*n+2] & g[4*n+1])
                  | (p[4*n+3] & p[4*n+2] & p[4*n+1] & g[4*n]);
            gp[n] = &p[4*n +: 4];
        end
        gc[0] = ci;
        for (int n = 0; n < 4; n++) begin
            gc[n+1] = gg[n] | (gp[n] & gc[n]);
        end
        for (int n = 0; n < 4; n++) begin
            c[4*n] = gc[n];
            for (int i = 1; i < 4; i++) begin
                c[4*n+i] = g[4*n+i-1] | (p[4*n+i-1] & c[4*n+i-1]);
            end
        end
        return {gc[4], p ^ c};
    endfunction

    logic [WIDTH-1:0]  a_reg    [STAGES];
    logic [WIDTH-1:0]  bb_reg   [STAGES];
    logic [WIDTH-1:0]  sum_reg  [STAGES];
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] carry_reg;
    logic [STAGES-1:0] sat_reg;
    logic              overflow_reg;
    logic              zero_reg;

    logic [WIDTH-1:0]  a_next   [STAGES];
    logic [WIDTH-1:0]  bb_next  [STAGES];
    logic [WIDTH-1:0]  sum_next [STAGES];
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] carry_next;
    logic [STAGES-1:0] sat_next;
    logic [STAGES-1:0] load;
    logic              overflow_next;
    logic              zero_next;
    logic              sat_in;

`ifdef PIPE_ADDER_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // A stage loads when it is empty or its content moves on; this ripples back from out_ready.
    always_comb begin
        load       = '0;
        load[LAST] = ~valid_reg[LAST] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            load[k] = ~valid_reg[k] | load[k+1];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [SEG:0]     seg_res;
        logic             carry_src;
        logic [WIDTH-1:0] sum_src;
        logic [WIDTH-1:0] merged;

        if (gi == 0) begin : g_first
            assign a_next[gi]     = a;
            assign bb_next[gi]    = b ^ {WIDTH{sub}};
            assign carry_src      = c_in ^ sub;
            assign sum_src        = '0;
            assign valid_next[gi] = in_valid;
            assign sat_next[gi]   = sat_in;
        end else begin : g_chain
            assign a_next[gi]     = a_reg[gi-1];
            assign bb_next[gi]    = bb_reg[gi-1];
            assign carry_src      = carry_reg[gi-1];
            assign sum_src        = sum_reg[gi-1];
            assign valid_next[gi] = valid_reg[gi-1];
            assign sat_next[gi]   = sat_reg[gi-1];
        end

        if (USE_CLA) begin : g_cla
            always_comb begin
                logic        c;
                logic [16:0] r;
                seg_res = '0;
                c       = carry_src;
                for (int j = 0; j < SEG / 16; j++) begin
                    r = cla16(a_next[gi][gi*SEG + j*16 +: 16], bb_next[gi][gi*SEG + j*16 +: 16], c);
                    seg_res[j*16 +: 16] = r[15:0];
                    c = r[16];
                end
                seg_res[SEG] = c;
            end
        end else begin : g_rca
            assign seg_res = {1'b0, a_next[gi][gi*SEG +: SEG]} + {1'b0, bb_next[gi][gi*SEG +: SEG]}
                           + {{SEG{1'b0}}, carry_src};
        end

        always_comb begin
            merged                 = sum_src;
            merged[gi*SEG +: SEG]  = seg_res[SEG-1:0];
        end
        assign carry_next[gi] = seg_res[SEG];

        if (gi == LAST) begin : g_last
            logic a_msb;
            logic ovf;
            assign a_msb = a_next[gi][WIDTH-1];
            assign ovf   = (a_msb == bb_next[gi][WIDTH-1]) & (merged[WIDTH-1] != a_msb);
            // Clamp direction follows the operand sign: positive overflow saturates high.
            assign sum_next[gi]  = (sat_next[gi] & ovf) ? {a_msb, {(WIDTH-1){~a_msb}}} : merged;
            assign overflow_next = ovf;
            assign zero_next     = ~|sum_next[gi];
        end else begin : g_mid
            assign sum_next[gi] = merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg    <= '0;
            carry_reg    <= '0;
            sat_reg      <= '0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_reg[k]   <= '0;
                bb_reg[k]  <= '0;
                sum_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    valid_reg[k] <= valid_next[k];
                    carry_reg[k] <= carry_next[k];
                    sat_reg[k]   <= sat_next[k];
                    a_reg[k]     <= a_next[k];
                    bb_reg[k]    <= bb_next[k];
                    sum_reg[k]   <= sum_next[k];
                end
            end
            if (load[LAST]) begin
                overflow_reg <= overflow_next;
                zero_reg     <= zero_next;
            end
        end
    end

    // Operand copies in the final stage have no consumer.
    logic unused_tail;
    assign unused_tail = ^{a_reg[LAST], bb_reg[LAST], sat_reg[LAST]};

    assign in_ready  = load[0];
    assign out_valid = valid_reg[LAST];
    assign sum       = sum_reg[LAST];
    assign c_out     = carry_reg[LAST];
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised and directed bench for pipe_adder, scored against an arithmetic reference model.
module tb_pipe_adder #(
    parameter int STAGES = 2
);
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             sat_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             zero;

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
`ifdef PIPE_ADDER_SAT_EN
        .sat      (sat_i),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero)
    );

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             c_out;
        logic             ovf;
        logic             zero;
    } res_t;

    res_t exp_q[$];
    res_t last_res;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   n_in = 0;
    int   n_out = 0;
    int   last_out_cyc = -1;
    bit   accepted;

    // Reference: unsigned sum for the carry, signed range test for overflow.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci_raw, input logic s, input logic sat_en);
        logic [31:0] yy;
        logic        ci;
        logic [32:0] full;
        longint      sres;
        res_t        r;
        yy    = s ? ~y : y;
        ci    = ci_raw ^ s;
        full  = {1'b0, x} + {1'b0, yy} + {32'd0, ci};
        sres  = longint'($signed(x)) + longint'($signed(yy)) + longint'(ci);
        r.c_out = full[32];
        r.ovf   = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
        r.sum   = full[31:0];
        if (sat_en && r.ovf) r.sum = (sres > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        r.zero  = (r.sum == 32'd0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_ops();
        a    = pick();
        b    = pick();
        c_in = 1'($urandom_range(0, 1));
        sub  = 1'($urandom_range(0, 1));
`ifdef PIPE_ADDER_SAT_EN
        sat_i = 1'($urandom_range(0, 1));
`endif
    endtask

    // One clock: sample at the falling edge, score output transfer, record input transfer.
    task automatic tick();
        res_t e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_out", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("sum", sum, e.sum);
                check("c_out", c_out, e.c_out);
                check("overflow", overflow, e.ovf);
                check("zero", zero, e.zero);
                last_res.sum   = sum;
                last_res.c_out = c_out;
                last_res.ovf   = overflow;
                last_res.zero  = zero;
                last_out_cyc   = cyc;
                n_out++;
                $display("out %0d @%0d: sum=0x%08h c_out=%0d ovf=%0d zero=%0d",
                         n_out, cyc, sum, c_out, overflow, zero);
            end
        end
        if (accepted) begin
            exp_q.push_back(model(a, b, c_in, sub, sat_i));
            n_in++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check(tag, exp_q.size(), 0);
    endtask

    task automatic send_one(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic s);
        int t_acc;
        int t_cur;
        t_acc = -1;
        a = x; b = y; c_in = ci; sub = s;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && t_acc < 0; i++) begin
            t_cur = cyc;
            tick();
            if (accepted) t_acc = t_cur;
        end
        in_valid = 1'b0;
        check("send_accept", t_acc >= 0, 1'b1);
        drain("send_drain");
        check("latency", last_out_cyc - t_acc, STAGES);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int n0;
        int n_in0;
        int cnt;
        int first;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        sat_i = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, 32'd0);
        check("rst_c_out", c_out, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_zero", zero, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1'b1);
        @(posedge clk); #1;

        // Carry crossing the segment boundary.
        send_one(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        check("t1_sum", last_res.sum, 32'h0001_0000);
        check("t1_c_out", last_res.c_out, 1'b0);
        check("t1_ovf", last_res.ovf, 1'b0);
        check("t1_zero", last_res.zero, 1'b0);

        send_one(32'd5, 32'd7, 1'b0, 1'b1);
        check("t2_sum", last_res.sum, 32'hFFFF_FFFE);
        check("t2_c_out", last_res.c_out, 1'b0);
        check("t2_ovf", last_res.ovf, 1'b0);
        send_one(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        check("t3_sum", last_res.sum, 32'h7FFF_FFFF);
        check("t3_ovf", last_res.ovf, 1'b1);
        check("t3_c_out", last_res.c_out, 1'b1);
        send_one(32'd9, 32'd4, 1'b1, 1'b1);
        check("t4_sum", last_res.sum, 32'd4);

        // Back-to-back stream: one result per cycle after fill.
        n0 = n_out; cnt = 0; first = cyc;
        out_ready = 1'b1; in_valid = 1'b1; rand_ops();
        for (int i = 0; i < 1000 && cnt < 100; i++) begin
            tick();
            if (accepted) begin
                cnt++;
                rand_ops();
            end
        end
        in_valid = 1'b0;
        drain("stream_drain");
        check("stream_count", n_out - n0, 100);
        check("stream_last_cycle", last_out_cyc - first, 99 + STAGES);

        // Backpressure with a full pipeline.
        n0 = n_out; n_in0 = n_in;
        out_ready = 1'b0; in_valid = 1'b1; rand_ops();
        repeat (STAGES) begin
            tick();
            if (accepted) rand_ops();
        end
        check("bp_fill", exp_q.size(), STAGES);
        repeat (5) begin
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
            if (exp_q.size() > 0) begin
                check("bp_sum", sum, exp_q[0].sum);
                check("bp_c_out", c_out, exp_q[0].c_out);
            end
            tick();
            if (accepted) rand_ops();
        end
        out_ready = 1'b1;
        repeat (10) begin
            tick();
            if (accepted) rand_ops();
        end
        in_valid = 1'b0;
        drain("bp_drain");
        check("bp_balance", n_out - n0, n_in - n_in0);

        // Random valid/ready traffic.
        n0 = n_out; n_in0 = n_in;
        in_valid = 1'b1; out_ready = 1'b1; rand_ops();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (accepted || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_ops();
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain("mix_drain");
        check("mix_balance", n_out - n0, n_in - n_in0);

        // Reset with results in flight.
        out_ready = 1'b0; in_valid = 1'b1; rand_ops();
        tick();
        if (accepted) rand_ops();
        tick();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_sum", sum, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        n0 = n_out;
        repeat (6) tick();
        check("no_stale", n_out - n0, 0);
        sat_i = 1'b0;
        send_one(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        check("t5_sum", last_res.sum, 32'd0);
        check("t5_zero", last_res.zero, 1'b1);
        check("t5_c_out", last_res.c_out, 1'b1);
        check("t5_ovf", last_res.ovf, 1'b0);

`ifdef PIPE_ADDER_SAT_EN
        sat_i = 1'b1;
        send_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        check("sat_pos_sum", last_res.sum, 32'h7FFF_FFFF);
        check("sat_pos_ovf", last_res.ovf, 1'b1);
        send_one(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        check("sat_neg_sum", last_res.sum, 32'h8000_0000);
        check("sat_neg_ovf", last_res.ovf, 1'b1);
        sat_i = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined two's-complement adder/subtractor for the miniRISC ALU path and for multi-cycle datapath experiments. WIDTH-bit operands are split into STAGES equal segments. One segment is summed per pipeline stage, and the carry is registered between stages. Valid/ready handshakes on input and output give one result per cycle at full throughput, with backpressure stalls.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 2, pipeline depth and segment count, 1..8; segment width SEG = WIDTH/STAGES.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands presented
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c_in  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0 = add, 1 = subtract
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
c_out  output  1  carry-out of MSB (sub: 1 = no borrow)
overflow  output  1  signed overflow
zero  output  1  sum == 0

Behaviour:
- Reset (async, rst=1): all stage valid bits, out_valid, sum, c_out, overflow and zero are 0. in_ready is 1 once rst deasserts.
- Effective operation: bb = b ^ {WIDTH{sub}}, cin = c_in ^ sub; result = a + bb + cin.
  - sub=1, c_in=0 gives a-b.
  - sub=1, c_in=1 gives a-b-1.
- Transfer rules:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready.
  - in_valid may be held; operands are sampled only on transfer.
- Stage k (1..STAGES) registers:
  - the segment k-1 sum bits;
  - the carry out of that segment;
  - the still-unsummed upper segments of a and bb;
  - the already-computed lower sum bits;
  - a valid bit.
  Stage 1 sums segment 0 combinationally from the inputs. Each later stage sums its segment using the registered carry from the previous stage.
- Outputs come directly from stage STAGES registers.
- Latency: a result accepted in cycle t is visible with out_valid=1 in cycle t+STAGES. STAGES=1 gives one registered cycle.
- Throughput: one transfer per cycle while out_ready=1.
- Stall: stage k advances iff stage k+1 is empty or advancing. The last stage advances iff out_valid=0 or out_ready=1. in_ready = ~v1 | stage-1 advances (combinational from out_ready through the chain; no skid buffer).
- Held data: a stalled stage holds all fields unchanged. out_valid, once high, stays high with stable sum/flags until out_ready.
- Flags, computed in the final stage:
  - c_out = carry out of bit WIDTH-1.
  - overflow = (a[MSB]==bb[MSB]) & (sum[MSB]!=a[MSB]).
  - zero = ~|sum.
- Wrap-around: the sum is modulo 2^WIDTH; c_out carries the lost bit. No internal counters.
- Simultaneous events:
  - Output and input transfer in the same cycle on a full pipeline: both occur, the pipeline stays full with no bubble.
  - in_valid=0 while draining: bubbles (valid=0) propagate.
- Reset mid-operation: all in-flight results are discarded immediately and no partial result is emitted.
- Segment sum implementation: the team's 16-bit CLA when SEG is a multiple of 16, behavioural + otherwise; results must be identical either way.

Optional Feature:
Macro PIPE_ADDER_SAT_EN.
- Defined: an extra input sat (1 bit) is sampled with the operands and carried down the pipeline. If sat=1 and overflow=1, sum is clamped: positive overflow gives 0x7FF..F, negative overflow gives 0x800..0. zero and c_out reflect the clamped/unclamped values as follows:
  - zero is computed on the clamped sum;
  - c_out is unclamped;
  - overflow still reports 1.
- Not defined: no sat port; sum always wraps.

Test Plan:
- Reset then single add, WIDTH=32/STAGES=2: a=0x0000FFFF, b=0x00000001, c_in=0, sub=0. Expect sum=0x00010000 with out_valid in cycle t+2, c_out=0, overflow=0, zero=0 (carry crosses the segment boundary).
- Subtract a=5, b=7, sub=1, c_in=0. Expect sum=0xFFFFFFFE, c_out=0, overflow=0. Then a=0x80000000, b=1 sub → sum=0x7FFFFFFF, overflow=1, c_out=1.
- Back-to-back 100 random operands, out_ready=1. Expect one result per cycle after 2-cycle fill, all matching the reference model, in order.
- Backpressure: out_ready=0 for 5 cycles with a full pipeline. Expect in_ready=0 after stages fill, sum stable. Release → no loss or duplication.
- Assert rst with 2 results in flight. Expect out_valid=0 at once and no stale result after release. Then a=0xFFFFFFFF, b=1 → sum=0, zero=1, c_out=1.
- With PIPE_ADDER_SAT_EN, sat=1: a=0x7FFFFFFF, b=1 → sum=0x7FFFFFFF, overflow=1. STAGES=1 and STAGES=4 builds pass the same vectors.
